// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and defaults for the dead-time gate driver
package pwm_pkg;

   localparam int DT_W_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LS_ON    = 3'd1,
      DT_TO_HS = 3'd2,
      HS_ON    = 3'd3,
      DT_TO_LS = 3'd4,
      FAULT    = 3'd5
   } pwm_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous level
module sync2 (
   input  logic Clock,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - complementary gate drive with programmable dead time and latched fault
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DT_W = DT_W_DEFAULT
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            PWM_i,
   input  logic [DT_W-1:0] Dead_time,
   input  logic            Dead_load,
   input  logic            Fault_i,
   input  logic            Fault_clr,
   output logic            HS_o,
   output logic            LS_o,
   output logic            Fault_o
);

   pwm_state_t      state, state_nxt;
   logic            pwm_r;
   logic            dead_load_r;
   logic            fault_s;
   logic [DT_W-1:0] dt_s;
   logic [DT_W-1:0] d_eff;
   logic [DT_W-1:0] cnt, cnt_nxt;

   sync2 u_fault_sync (
      .Clock (Clock),
      .Reset (Reset),
      .d     (Fault_i),
      .q     (fault_s)
   );

   // Shadow load is independent of the FSM, so it keeps working while faulted.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pwm_r       <= 1'b0;
         dead_load_r <= 1'b0;
         dt_s        <= '0;
      end else begin
         pwm_r       <= PWM_i;
         dead_load_r <= Dead_load;
         if (Dead_load && !dead_load_r)
            dt_s <= Dead_time;
      end
   end

   assign d_eff = (dt_s == '0) ? DT_W'(1) : dt_s;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (fault_s) begin
         state_nxt = FAULT;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = pwm_r ? DT_TO_HS : DT_TO_LS;
               cnt_nxt   = d_eff;
            end
            LS_ON: begin
               if (pwm_r) begin
                  state_nxt = DT_TO_HS;
                  cnt_nxt   = d_eff;
               end
            end
            HS_ON: begin
               if (!pwm_r) begin
                  state_nxt = DT_TO_LS;
                  cnt_nxt   = d_eff;
               end
            end
            // A reversal mid-dead-time restarts a full period toward the other side.
            DT_TO_HS: begin
               if (!pwm_r) begin
                  state_nxt = DT_TO_LS;
                  cnt_nxt   = d_eff;
               end else if (cnt <= DT_W'(1)) begin
                  state_nxt = HS_ON;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            DT_TO_LS: begin
               if (pwm_r) begin
                  state_nxt = DT_TO_HS;
                  cnt_nxt   = d_eff;
               end else if (cnt <= DT_W'(1)) begin
                  state_nxt = LS_ON;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            FAULT: begin
               if (Fault_clr)
                  state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         HS_o    <= 1'b0;
         LS_o    <= 1'b0;
         Fault_o <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         HS_o    <= (state_nxt == HS_ON);
         LS_o    <= (state_nxt == LS_ON);
         Fault_o <= (state_nxt == FAULT);
      end
   end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter DT_W, default 8, meaning the width of the dead-time value in clock cycles.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port PWM_i, input, 1 bit: raw PWM from the upstream triangle-counter PWM stage, synchronous to Clock.
REQ-005 SHALL have port Dead_time, input, DT_W bits: requested dead time in cycles.
REQ-006 SHALL have port Dead_load, input, 1 bit: load strobe for Dead_time.
REQ-007 SHALL have port Fault_i, input, 1 bit: asynchronous external fault, active-high.
REQ-008 SHALL have port Fault_clr, input, 1 bit: fault-clear strobe, synchronous.
REQ-009 SHALL have port HS_o, output, 1 bit: high-side gate drive, registered.
REQ-010 SHALL have port LS_o, output, 1 bit: low-side gate drive, registered.
REQ-011 SHALL have port Fault_o, output, 1 bit: latched fault indicator, registered.

Function
REQ-012 SHALL register PWM_i into pwm_r each cycle; all state decisions use pwm_r.
REQ-013 SHALL hold a shadow register dt_s, updated from Dead_time on the cycle after a 0->1 edge of Dead_load; a level held high SHALL NOT reload.
REQ-014 SHALL use an effective dead time D = max(dt_s, 1), captured at the start of each dead period; a dt_s change mid-period SHALL NOT affect that period.
REQ-015 SHALL implement the states IDLE, LS_ON, DT_TO_HS, HS_ON, DT_TO_LS and FAULT.
REQ-016 SHALL make the IDLE transitions: pwm_r=0 -> DT_TO_LS; pwm_r=1 -> DT_TO_HS; in both cases the counter loads D.
REQ-017 SHALL make the LS_ON transition: pwm_r=1 -> DT_TO_HS, with the counter loading D.
REQ-018 SHALL make the HS_ON transition: pwm_r=0 -> DT_TO_LS, with the counter loading D.
REQ-019 SHALL make the DT_TO_HS transitions: the counter decrements each cycle; at counter=1 with pwm_r=1 -> HS_ON; if pwm_r returns to 0 before completion -> DT_TO_LS with the counter reloaded to D (abort; a pulse shorter than D is suppressed).
REQ-020 SHALL make the DT_TO_LS transitions symmetric to REQ-019, with HS and LS swapped and pwm_r inverted.
REQ-021 SHALL drive the outputs as follows: HS_o=1 only in HS_ON; LS_o=1 only in LS_ON; both 0 in all other states; HS_o and LS_o SHALL never be 1 in the same cycle.
REQ-022 SHALL meet this latency: the active output falls 1 cycle after the pwm_r change; the opposite output rises exactly D cycles after that fall.
REQ-023 SHALL synchronize Fault_i through 2 flops before use; Fault_i is the only asynchronous input.
REQ-024 SHALL go from any state to FAULT on a synchronized fault; HS_o, LS_o and Fault_o SHALL take 0, 0 and 1 on the next edge; fault has priority over every other transition.
REQ-025 SHALL leave FAULT for IDLE only on Fault_clr=1 with the synchronized fault at 0; Fault_clr while the fault is still high SHALL be ignored.
REQ-026 SHALL ignore Dead_load while in FAULT, but the shadow register dt_s SHALL still update.

Reset
REQ-027 SHALL, on Reset, clear state to IDLE, HS_o=0, LS_o=0, Fault_o=0, pwm_r=0, dt_s=0, counter=0, and the synchronizer flops to 0.
REQ-028 SHALL return both outputs to 0 immediately on a Reset assertion mid-dead-time or mid-pulse, without waiting for a clock edge.

Structure
REQ-029 SHALL place the state encoding and the DT_W default in the shared package pwm_pkg.
REQ-030 SHALL implement the 2-flop fault synchronizer as sub-module sync2, instantiated once.

Verification
REQ-031 SHALL verify: Dead_time=5 loaded, PWM_i 0->1 -> LS_o falls 1 cycle later, HS_o rises 5 cycles after that, and neither output is ever high together.
REQ-032 SHALL verify: Dead_time=0 -> both outputs are low for exactly 1 cycle at each transition.
REQ-033 SHALL verify: Dead_time=10, a 4-cycle high pulse on PWM_i -> HS_o stays 0, and LS_o returns 10 cycles after the abort.
REQ-034 SHALL verify: Fault_i pulsed during HS_ON -> HS_o=0 and Fault_o=1 within 3 cycles; Fault_clr while Fault_i is high is ignored; after Fault_i goes low, Fault_clr -> IDLE, then the dead period, then the output matches PWM_i.
REQ-035 SHALL verify: Dead_load held high for 20 cycles while Dead_time changes -> only the value at the rising edge is used; an update during DT_TO_HS applies only from the next dead period.
REQ-036 SHALL verify: Reset asserted mid-DT_TO_LS -> HS_o=0 and LS_o=0 asynchronously, and after release IDLE then a full D-cycle dead period.
